// File: rtl/push_seq_6801.sv
// Stack push sequencer: writes PC / X / ACCA / full interrupt frame downward from sp_in, one byte per cycle.
// Optional STACK_WRAP_FLAG_EN macro adds a sticky stack_wrap output for sp_out wrapping past 0x0000.
module push_seq_6801 (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] pc,
  input  logic [15:0] xreg,
  input  logic [15:0] sp_in,
  input  logic [7:0]  acca,
  input  logic [7:0]  accb,
  input  logic [7:0]  ccr,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        we,
  output logic [15:0] sp_out,
  output logic        busy,
  output logic        done
`ifdef STACK_WRAP_FLAG_EN
  ,
  output logic        stack_wrap
`endif
);

  typedef enum logic [1:0] {IDLE, PUSH, DONE} state_t;

  state_t      state_q;
  logic [1:0]  mode_q;
  logic [15:0] pc_q, x_q, sp_q, addr_q;
  logic [7:0]  a_q, b_q, c_q, data_q;
  logic [2:0]  k_q;
  logic        busy_q, done_q;
  logic [15:0] sp_dec;
  logic        last_byte;

  // Byte k of the push sequence for a given mode; out-of-range k yields 0.
  function automatic logic [7:0] sel_byte(input logic [1:0] m, input logic [2:0] k,
                                          input logic [15:0] p, input logic [15:0] x,
                                          input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (m)
      2'd0: if (k == 3'd0) r = p[7:0]; else if (k == 3'd1) r = p[15:8];
      2'd1:
        case (k)
          3'd0:    r = p[7:0];
          3'd1:    r = p[15:8];
          3'd2:    r = x[7:0];
          3'd3:    r = x[15:8];
          3'd4:    r = a;
          3'd5:    r = b;
          3'd6:    r = c;
          default: r = 8'h00;
        endcase
      2'd2: if (k == 3'd0) r = a;
      default: if (k == 3'd0) r = x[7:0]; else if (k == 3'd1) r = x[15:8];
    endcase
    return r;
  endfunction

  function automatic logic [2:0] last_k(input logic [1:0] m);
    case (m)
      2'd1:    return 3'd6;
      2'd2:    return 3'd0;
      default: return 3'd1;
    endcase
  endfunction

  assign sp_dec    = sp_q - 16'd1;
  assign last_byte = (k_q == last_k(mode_q));

  // The strobe must drop in the same cycle hold rises, so it is gated rather than registered.
  assign we       = (state_q == PUSH) && !hold;
  assign addr     = addr_q;
  assign data_out = data_q;
  assign sp_out   = sp_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef STACK_WRAP_FLAG_EN
  logic wrap_q;
  assign stack_wrap = wrap_q;
`endif

  // NOTE: every register here uses <= so all updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      pc_q    <= 16'h0000;
      x_q     <= 16'h0000;
      sp_q    <= 16'h0000;
      addr_q  <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      c_q     <= 8'h00;
      data_q  <= 8'h00;
      k_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STACK_WRAP_FLAG_EN
      wrap_q  <= 1'b0;
`endif
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            pc_q    <= pc;
            x_q     <= xreg;
            a_q     <= acca;
            b_q     <= accb;
            c_q     <= ccr;
            sp_q    <= sp_in;
            addr_q  <= sp_in;
            data_q  <= sel_byte(mode, 3'd0, pc, xreg, acca, accb, ccr);
            k_q     <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= PUSH;
`ifdef STACK_WRAP_FLAG_EN
            wrap_q  <= 1'b0;
`endif
          end
        end
        PUSH: begin
          // addr/data are preloaded with the following byte so they are valid the moment we rises.
          sp_q   <= sp_dec;
          addr_q <= sp_dec;
          k_q    <= k_q + 3'd1;
          data_q <= sel_byte(mode_q, k_q + 3'd1, pc_q, x_q, a_q, b_q, c_q);
`ifdef STACK_WRAP_FLAG_EN
          if (sp_q == 16'h0000) wrap_q <= 1'b1;
`endif
          if (last_byte) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_push_seq_6801.sv
// Self-checking bench for push_seq_6801: a write scoreboard is filled when a sequence is started
// and drained whenever the DUT strobes we; timing, sp_out and handshake outputs are checked per scenario.
module tb_push_seq_6801;

  logic        clk = 1'b0;
  logic        reset, hold, start;
  logic [1:0]  mode;
  logic [15:0] pc, xreg, sp_in;
  logic [7:0]  acca, accb, ccr;
  logic [15:0] addr, sp_out;
  logic [7:0]  data_out;
  logic        we, busy, done;
`ifdef STACK_WRAP_FLAG_EN
  logic        stack_wrap;
`endif

  always #5 clk = ~clk;

  push_seq_6801 dut (
    .clk(clk), .reset(reset), .hold(hold), .start(start), .mode(mode),
    .pc(pc), .xreg(xreg), .sp_in(sp_in), .acca(acca), .accb(accb), .ccr(ccr),
    .addr(addr), .data_out(data_out), .we(we), .sp_out(sp_out), .busy(busy), .done(done)
`ifdef STACK_WRAP_FLAG_EN
    , .stack_wrap(stack_wrap)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [23:0] sb[$];
  int cyc, wr_cnt, done_cnt, done_cyc;

  // One clock cycle: sample on the falling edge, drain the scoreboard on each write strobe.
  task automatic tick();
    logic [23:0] exp;
    @(negedge clk);
    cyc++;
    if (we === 1'b1) begin
      checks++;
      wr_cnt++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got %h:%h expected no write (cycle %0d)", addr, data_out, cyc);
      end else begin
        exp = sb.pop_front();
        if ({addr, data_out} !== exp) begin
          failures++;
          $display("FAIL write_data got %h:%h expected %h:%h (cycle %0d)",
                   addr, data_out, exp[23:8], exp[7:0], cyc);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  function automatic int n_of(input logic [1:0] m);
    case (m)
      2'd1:    return 7;
      2'd2:    return 1;
      default: return 2;
    endcase
  endfunction

  // Reference byte list per mode, addresses descending from s.
  task automatic push_exp(input logic [1:0] m, input logic [15:0] p, input logic [15:0] x,
                          input logic [15:0] s, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    logic [7:0]  bytes[$];
    logic [15:0] sa;
    case (m)
      2'd0:    bytes = '{p[7:0], p[15:8]};
      2'd1:    bytes = '{p[7:0], p[15:8], x[7:0], x[15:8], a, b, c};
      2'd2:    bytes = '{a};
      default: bytes = '{x[7:0], x[15:8]};
    endcase
    sa = s;
    foreach (bytes[i]) begin
      sb.push_back({sa, bytes[i]});
      sa = sa - 16'd1;
    end
  endtask

  // Present a request for one edge, then scramble operands to show they were captured.
  task automatic kick(input logic [1:0] m, input logic [15:0] p, input logic [15:0] x,
                      input logic [15:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    mode = m; pc = p; xreg = x; sp_in = s; acca = a; accb = b; ccr = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 2'($urandom); pc = 16'($urandom); xreg = 16'($urandom); sp_in = 16'($urandom);
    acca = 8'($urandom); accb = 8'($urandom); ccr = 8'($urandom);
    cyc = 0; wr_cnt = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic run_done(input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_check(input string name, input int n, input int dcyc, input logic [15:0] sp);
    tick();
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL %s done_count got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_cyc !== dcyc) begin
      failures++;
      $display("FAIL %s done_cycle got %0d expected %0d", name, done_cyc, dcyc);
    end
    checks++;
    if (wr_cnt !== n) begin
      failures++;
      $display("FAIL %s write_count got %0d expected %0d", name, wr_cnt, n);
    end
    checks++;
    if (sp_out !== sp) begin
      failures++;
      $display("FAIL %s sp_out got %h expected %h", name, sp_out, sp);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_writes got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if ({busy, done, we} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle_flags got busy=%b done=%b we=%b expected 0 0 0", name, busy, done, we);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b1; start = 1'b1; mode = 2'd1;
    pc = 16'h1111; xreg = 16'h2222; sp_in = 16'h3333; acca = 8'h44; accb = 8'h55; ccr = 8'h66;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({addr, data_out, we, sp_out, busy, done} !== 44'h0) begin
      failures++;
      $display("FAIL reset_state got addr=%h data=%h we=%b sp=%h busy=%b done=%b expected all zero",
               addr, data_out, we, sp_out, busy, done);
    end
    reset = 1'b0;
    cyc = 0; wr_cnt = 0; done_cnt = 0;
    tick();
    checks++;
    if ({busy, we} !== 2'b00) begin
      failures++;
      $display("FAIL start_during_hold got busy=%b we=%b expected 0 0", busy, we);
    end
    hold = 1'b0; start = 1'b0;
    tick();
    checks++;
    if ({busy, we, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_hold got busy=%b we=%b done=%b expected 0 0 0", busy, we, done);
    end
  endtask

  task automatic test_irq_frame();
    sb.push_back({16'h00FF, 8'h34}); sb.push_back({16'h00FE, 8'h12});
    sb.push_back({16'h00FD, 8'hCD}); sb.push_back({16'h00FC, 8'hAB});
    sb.push_back({16'h00FB, 8'h11}); sb.push_back({16'h00FA, 8'h22});
    sb.push_back({16'h00F9, 8'hC5});
    kick(2'd1, 16'h1234, 16'hABCD, 16'h00FF, 8'h11, 8'h22, 8'hC5);
    run_done(20);
    finish_check("irq_frame", 7, 8, 16'h00F8);
  endtask

  task automatic test_mode0_busy_start();
    sb.push_back({16'h0100, 8'h00}); sb.push_back({16'h00FF, 8'hE0});
    kick(2'd0, 16'hE000, 16'h0000, 16'h0100, 8'h00, 8'h00, 8'h00);
    tick();
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1;
    tick();
    @(posedge clk); #1;
    start = 1'b0;
    run_done(10);
    finish_check("mode0_busy_start", 2, 3, 16'h00FE);
  endtask

  task automatic test_hold();
    push_exp(2'd1, 16'h1234, 16'hABCD, 16'h00FF, 8'h11, 8'h22, 8'hC5);
    kick(2'd1, 16'h1234, 16'hABCD, 16'h00FF, 8'h11, 8'h22, 8'hC5);
    tick();
    tick();
    @(posedge clk); #1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({we, busy, addr, data_out, sp_out} !== {1'b0, 1'b1, 16'h00FD, 8'hCD, 16'h00FD}) begin
        failures++;
        $display("FAIL hold_freeze[%0d] got we=%b busy=%b addr=%h data=%h sp=%h expected 0 1 00fd cd 00fd",
                 i, we, busy, addr, data_out, sp_out);
      end
    end
    @(posedge clk); #1;
    hold = 1'b0;
    run_done(20);
    finish_check("hold", 7, 11, 16'h00F8);
  endtask

  task automatic test_reset_mid();
    push_exp(2'd1, 16'h1234, 16'hABCD, 16'h00FF, 8'h11, 8'h22, 8'hC5);
    kick(2'd1, 16'h1234, 16'hABCD, 16'h00FF, 8'h11, 8'h22, 8'hC5);
    repeat (3) tick();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    tick();
    checks++;
    if ({we, busy, done, sp_out} !== 19'h0) begin
      failures++;
      $display("FAIL reset_abort got we=%b busy=%b done=%b sp=%h expected 0 0 0 0000", we, busy, done, sp_out);
    end
    repeat (10) tick();
    checks++;
    if (done_cnt !== 0 || wr_cnt !== 4) begin
      failures++;
      $display("FAIL reset_abort_counts got done=%0d writes=%0d expected 0 4", done_cnt, wr_cnt);
    end
  endtask

  task automatic test_wrap();
    sb.push_back({16'h0000, 8'h5B}); sb.push_back({16'hFFFF, 8'h5A});
    kick(2'd3, 16'h9999, 16'h5A5B, 16'h0000, 8'h01, 8'h02, 8'h03);
    run_done(10);
`ifdef STACK_WRAP_FLAG_EN
    checks++;
    if (stack_wrap !== 1'b1) begin
      failures++;
      $display("FAIL stack_wrap_set got %b expected 1", stack_wrap);
    end
`endif
    finish_check("wrap", 2, 3, 16'hFFFE);
  endtask

  task automatic test_mode2();
    sb.push_back({16'h0080, 8'h7E});
    kick(2'd2, 16'h4321, 16'h8765, 16'h0080, 8'h7E, 8'h99, 8'h88);
`ifdef STACK_WRAP_FLAG_EN
    checks++;
    if (stack_wrap !== 1'b0) begin
      failures++;
      $display("FAIL stack_wrap_clear got %b expected 0", stack_wrap);
    end
`endif
    run_done(10);
    finish_check("mode2", 1, 2, 16'h007F);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  m;
    logic [15:0] p, x, s;
    logic [7:0]  a, b, c;
    int          n;
    for (int i = 0; i < 8; i++) begin
      m = 2'($urandom);
      p = 16'($urandom); x = 16'($urandom);
      s = (i < 3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      n = n_of(m);
      push_exp(m, p, x, s, a, b, c);
      kick(m, p, x, s, a, b, c);
      run_done(20);
      finish_check($sformatf("b2b_%0d_mode%0d", i, m), n, n + 1, s - 16'(n));
    end
  endtask

  initial begin
    test_reset();
    test_irq_frame();
    test_mode0_busy_start();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_mode2();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/push_seq_6801.md
PUSH_SEQ_6801 -- requirements
Module: push_seq_6801

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port hold, input, 1 bit: when 1, all internal state and registered outputs freeze.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a push sequence.
REQ-005 The block SHALL have port mode, input, 2 bits: 0 = push PC (2 bytes), 1 = interrupt frame (7 bytes), 2 = push ACCA (1 byte), 3 = push X (2 bytes).
REQ-006 The block SHALL have ports pc, xreg and sp_in, inputs, 16 bits each: the program counter, index register and stack pointer values to push from.
REQ-007 The block SHALL have ports acca, accb and ccr, inputs, 8 bits each: the accumulator and condition code values to push.
REQ-008 The block SHALL have port addr, output, 16 bits: the memory write address.
REQ-009 The block SHALL have port data_out, output, 8 bits: the memory write data.
REQ-010 The block SHALL have port we, output, 1 bit: the write strobe, 1 for exactly one cycle per byte.
REQ-011 The block SHALL have port sp_out, output, 16 bits: the live stack pointer.
REQ-012 The block SHALL have port busy, output, 1 bit: 1 while the sequence is not idle.
REQ-013 The block SHALL have port done, output, 1 bit: a 1-cycle completion pulse.

Function
REQ-014 The FSM SHALL have three states: IDLE, PUSH and DONE.
REQ-015 In IDLE with hold=0 and start=1, the block SHALL capture mode, pc, xreg, acca, accb, ccr and sp_in, clear the byte index k to 0, and enter PUSH.
REQ-016 In PUSH, each non-hold cycle SHALL drive we=1, addr=sp_out and data_out=byte k, then decrement sp_out by 1 (mod 2^16) and increment k.
REQ-017 Byte order for mode 1 SHALL be: PCL, PCH, XL, XH, ACCA, ACCB, CCR.
REQ-018 Byte order for mode 0 SHALL be PCL then PCH; for mode 3, XL then XH; for mode 2, ACCA only.
REQ-019 After the last byte, the FSM SHALL enter DONE; DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-020 Latency from the start-sample edge SHALL be N write cycles followed by 1 done cycle, where N = 2, 7, 1 or 2 for mode 0, 1, 2 or 3.
REQ-021 The final value of sp_out SHALL be sp_in - N.
REQ-022 start SHALL be ignored outside IDLE, and operand inputs SHALL be ignored after capture.
REQ-023 Outside PUSH, or whenever hold=1, we SHALL be 0; during hold, addr, data_out, sp_out, k and the state SHALL not change.
REQ-024 When hold deasserts, the sequence SHALL resume at the same byte, with no byte skipped or duplicated.
REQ-025 A decrement from 0x0000 SHALL wrap to 0xFFFF.
REQ-026 If start and hold are both 1 in IDLE, start SHALL not be accepted in that cycle.

Reset
REQ-027 reset SHALL override hold and start.
REQ-028 On reset, the state SHALL go to IDLE; sp_out, addr and k SHALL be 0x0000 or 0; data_out SHALL be 0x00; we, busy and done SHALL be 0.
REQ-029 A reset asserted mid-sequence SHALL abort the sequence: no further we pulses, and no done pulse.

Configuration
REQ-030 With macro STACK_WRAP_FLAG_EN defined, the block SHALL add output stack_wrap (1 bit, reset 0).
REQ-031 stack_wrap SHALL be set when any push in the sequence decrements sp_out from 0x0000 to 0xFFFF, and cleared on acceptance of the next start.
REQ-032 Without STACK_WRAP_FLAG_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Interrupt frame: mode=1, sp_in=0x00FF, pc=0x1234, xreg=0xABCD, acca=0x11, accb=0x22, ccr=0xC5 -> writes 00FF:34, 00FE:12, 00FD:CD, 00FC:AB, 00FB:11, 00FA:22, 00F9:C5; done on cycle 8; sp_out=0x00F8.
REQ-034 Mode 0 with pc=0xE000 and sp_in=0x0100 -> writes 0100:00, 00FF:E0; sp_out=0x00FE; start pulsed while busy is ignored.
REQ-035 Hold=1 for 3 cycles after the second byte of mode 1 -> we=0 and outputs frozen; the third byte (XL) is written on the first cycle after release; total 7 writes.
REQ-036 Reset asserted on the 4th write of mode 1 -> next cycle IDLE, we=0, done never asserts, sp_out=0x0000.
REQ-037 Mode 3 with sp_in=0x0000 and xreg=0x5A5B -> writes 0000:5B, FFFF:5A; sp_out=0xFFFE; with STACK_WRAP_FLAG_EN, stack_wrap=1 after done.
REQ-038 Mode 2 with acca=0x7E and sp_in=0x0080 -> a single write 0080:7E; done on the next cycle; sp_out=0x007F.
